// File: rtl/gs_pkg.sv
// Shared defaults and the reciprocal-seed generator for the Goldschmidt divider.
// The generator is used both to build the ROM and by reference models.
package gs_pkg;

    localparam int unsigned GS_DIV_W  = 16;
    localparam int unsigned GS_SEED_W = 8;
    localparam int unsigned GS_TAG_W  = 4;

    // Seed for table entry i; round_mid selects interval midpoint instead of lower edge.
    function automatic int unsigned gs_seed_val(input int unsigned i,
                                                input int unsigned addr_w,
                                                input int unsigned seed_w,
                                                input int unsigned round_mid);
        longint unsigned num;
        longint unsigned den;
        longint unsigned q;
        longint unsigned lim;
        if (round_mid != 0) begin
            num = 64'd1 << (addr_w + seed_w + 1);
            den = (64'd1 << (addr_w + 1)) + 64'(2 * i) + 64'd1;
        end else begin
            num = 64'd1 << (addr_w + seed_w);
            den = (64'd1 << addr_w) + 64'(i);
        end
        q   = num / den;
        lim = (64'd1 << seed_w) - 64'd1;
        if (q > lim) begin
            q = lim;
        end
        return int'(q);
    endfunction

endpackage

// File: rtl/gs_pipe_reg.sv
// Single valid/ready register slice; accepts whenever it is empty or being drained,
// and only overwrites its payload when a valid item arrives.
module gs_pipe_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/gs_seed_rom.sv
// Two-stage pipelined reciprocal-seed ROM: slice 1 captures index/tag/err,
// the table lookup sits between slice 1 and slice 2, slice 2 drives the outputs.
module gs_seed_rom
    import gs_pkg::*;
#(
    parameter int unsigned DIV_W     = GS_DIV_W,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned SEED_W    = GS_SEED_W,
    parameter int unsigned TAG_W     = GS_TAG_W,
    parameter int unsigned ROUND_MID = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIV_W-1:0]  in_div,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SEED_W-1:0] out_seed,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    localparam int unsigned S1_W    = ADDR_W + TAG_W + 1;
    localparam int unsigned S2_W    = SEED_W + TAG_W + 1;
    localparam int unsigned ENTRIES = 1 << ADDR_W;

    logic [SEED_W-1:0] rom [ENTRIES];

    for (genvar g = 0; g < ENTRIES; g++) begin : g_rom
        assign rom[g] = SEED_W'(gs_seed_val(g, ADDR_W, SEED_W, ROUND_MID));
    end

    // Only the index bits and the MSB matter; the rest of the mantissa is ignored.
    logic unused_div;
    assign unused_div = ^in_div;

    logic [S1_W-1:0]   s1_in;
    logic [S1_W-1:0]   s1_out;
    logic              s1_valid;
    logic              s2_ready;
    logic [ADDR_W-1:0] s1_idx;
    logic [TAG_W-1:0]  s1_tag;
    logic              s1_err;
    logic [SEED_W-1:0] s1_seed;
    logic [S2_W-1:0]   s2_in;
    logic [S2_W-1:0]   s2_out;

    assign s1_in = {in_div[DIV_W-2 -: ADDR_W], in_tag, ~in_div[DIV_W-1]};
    assign {s1_idx, s1_tag, s1_err} = s1_out;

    gs_pipe_reg #(
        .W (S1_W)
    ) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_out)
    );

    assign s1_seed = s1_err ? '0 : rom[s1_idx];
    assign s2_in   = {s1_seed, s1_tag, s1_err};

    gs_pipe_reg #(
        .W (S2_W)
    ) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_out)
    );

    assign {out_seed, out_tag, out_err} = s2_out;

endmodule
